// File: rtl/stream_coord_source_if.sv
// Ready/valid stream bundle for the 17-bit tokenised stream.
//   data_out  : stream word, driven by the source
//   valid_out : data_out holds a valid word, driven by the source
//   ready_in  : the sink can accept a word, driven by the sink
interface stream_coord_source_if #(
  parameter int unsigned DATA_WIDTH = 17
);
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  ready_in;

  modport master (output data_out, output valid_out, input ready_in);
  modport slave  (input data_out, input valid_out, output ready_in);
endinterface

// File: rtl/stream_coord_source.sv
// Coordinate stream source: on start, emits base, base+stride, ... (count
// words), then a stop token carrying stop_level, then a done token, and
// pulses done once the done token is accepted.
//   clk, rst_n     : clock, synchronous active-low reset
//   clk_en         : global enable; all state freezes while low
//   start          : begin a sequence (honoured only when idle)
//   base/stride    : first coordinate and increment (16-bit, wrapping)
//   count          : number of coordinates (0 allowed)
//   stop_level     : level field of the stop token
//   strm (master)  : data_out / valid_out / ready_in stream
//   busy           : high whenever not idle
//   done           : one-cycle pulse after the done token handshake
module stream_coord_source #(
  parameter int unsigned DATA_WIDTH  = 17,
  parameter int unsigned LEVEL_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clk_en,
  input  logic                   start,
  input  logic [15:0]            base,
  input  logic [15:0]            stride,
  input  logic [15:0]            count,
  input  logic [LEVEL_WIDTH-1:0] stop_level,
  stream_coord_source_if.master  strm,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned PAY_W = 16;
  localparam logic [DATA_WIDTH-1:0] DONE_TOK = DATA_WIDTH'(17'h10100);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_STOP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                 state;
  logic [PAY_W-1:0]       stride_q;
  logic [PAY_W-1:0]       count_q;
  logic [PAY_W-1:0]       idx_q;
  logic [LEVEL_WIDTH-1:0] level_q;

  logic             hs_c;
  logic [PAY_W-1:0] next_coord_c;

  // Stop token: control flag set, level zero-extended into the payload.
  function automatic logic [DATA_WIDTH-1:0] stop_tok(input logic [LEVEL_WIDTH-1:0] lvl);
    return DATA_WIDTH'({1'b1, PAY_W'(lvl)});
  endfunction

  assign hs_c         = clk_en && strm.valid_out && strm.ready_in;
  assign next_coord_c = strm.data_out[PAY_W-1:0] + stride_q;

  // Sequencer: every output is a register, advanced only by a handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      stride_q       <= '0;
      count_q        <= '0;
      idx_q          <= '0;
      level_q        <= '0;
      strm.data_out  <= '0;
      strm.valid_out <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else if (clk_en) begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          // A start coinciding with the done pulse is dropped.
          if (start && !done) begin
            stride_q       <= stride;
            count_q        <= count;
            level_q        <= stop_level;
            busy           <= 1'b1;
            strm.valid_out <= 1'b1;
            if (count != '0) begin
              strm.data_out <= DATA_WIDTH'({1'b0, base});
              idx_q         <= PAY_W'(1);
              state         <= S_EMIT;
            end else begin
              strm.data_out <= stop_tok(stop_level);
              state         <= S_STOP;
            end
          end
        end
        S_EMIT: begin
          if (hs_c) begin
            if (idx_q < count_q) begin
              strm.data_out <= DATA_WIDTH'({1'b0, next_coord_c});
              idx_q         <= idx_q + PAY_W'(1);
            end else begin
              strm.data_out <= stop_tok(level_q);
              state         <= S_STOP;
            end
          end
        end
        S_STOP: begin
          if (hs_c) begin
            strm.data_out <= DONE_TOK;
            state         <= S_DONE;
          end
        end
        S_DONE: begin
          if (hs_c) begin
            strm.data_out  <= '0;
            strm.valid_out <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b1;
            state          <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/stream_coord_source.md
Name: stream_coord_source

Overview:
- Ready/valid transmitter for the 17-bit tokenised stream. It sits upstream of the one-entry split FIFO stages and feeds them in the same protocol.
- When started, it emits an arithmetic sequence of 16-bit coordinates, then a stop token, then a done token, and returns to idle.
- Used as the configurable coordinate generator at the head of a stream pipeline, and as the reference traffic source in stream benches.

Parameters:
- DATA_WIDTH, 17, stream word width. Bit 16 is the control flag; bits 15:0 are the payload. Only 17 is supported.
- LEVEL_WIDTH, 4, width of the stop-token level field.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active-low
- clk_en  in  1  global clock enable. When low, all state freezes.
- start  in  1  one-cycle request to begin a sequence. Sampled only in IDLE.
- base  in  16  first coordinate
- stride  in  16  increment between coordinates
- count  in  16  number of coordinates to emit; 0 is legal
- stop_level  in  LEVEL_WIDTH  level field written into the stop token
- data_out  out  17  stream word
- valid_out  out  1  data_out holds a valid word
- ready_in  in  1  downstream can accept a word
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the done token is accepted

Behaviour:
- Reset: when rst_n=0 at a clock edge, the FSM goes to IDLE.
  - Reset values: data_out=17'h0, valid_out=0, busy=0, done=0, all counters and latched configuration = 0.
  - Reset overrides clk_en.
  - Reset in the middle of a sequence abandons it; no stop or done token is emitted.
- A handshake (hs) occurs when clk_en && valid_out && ready_in at a clock edge. Only a handshake advances the word.
- clk_en=0:
  - No state, counter, or output register updates.
  - valid_out and data_out hold their values.
  - No handshake is counted, even if ready_in=1.
- Valid rules:
  - Once valid_out=1, valid_out and data_out stay stable until the handshake.
  - valid_out never depends combinationally on ready_in.
  - All outputs are registered.
- FSM states: IDLE, EMIT, STOP, DONE.
- IDLE → EMIT or STOP:
  - On clk_en && start, latch base, stride, count and stop_level.
  - If count≠0: enter EMIT with data_out={1'b0, base}, valid_out=1, index=1.
  - If count=0: enter STOP directly with the stop token presented.
- EMIT: on each handshake:
  - If index<count: data_out={1'b0, previous payload + stride}, computed modulo 2^16 (wrap-around silently; no flag), index+=1.
  - If index==count: present the stop token and go to STOP.
- STOP token = {1'b1, 11'h000, 1'b0, stop_level}, zero-extended into bits 15:0, i.e. 17'h10000 | stop_level.
  - On handshake: present the done token 17'h10100 and go to DONE.
- DONE: on handshake, set valid_out=0, data_out=0, done=1 for exactly one clk_en cycle, then return to IDLE.
- Latency and throughput:
  - The first word is valid the cycle after start.
  - With ready_in held high, the block sustains one word per cycle.
  - A full sequence takes count+2 handshakes.
- start:
  - Ignored while busy=1; a new sequence begins only from IDLE.
  - A start in the same cycle as the done pulse is ignored. The earliest restart is the cycle after done.
- Configuration inputs are sampled only at start. Changes during a sequence have no effect.
- busy=1 from the cycle after an accepted start until the cycle the FSM re-enters IDLE (the done-pulse cycle).

Test Plan:
- Basic sequence, ready_in=1 constantly: base=5, stride=3, count=4, stop_level=2.
  - Required words on consecutive cycles: 0x00005, 0x00008, 0x0000B, 0x0000E, 0x10002, 0x10100.
  - done pulses one cycle after the last word; busy=0 afterwards.
- Backpressure: same configuration, ready_in toggling 1,0,0,1,...
  - Each word is held stable while ready_in=0.
  - The sequence is identical, with no duplicates or drops; valid_out never drops before the handshake.
- Empty and wrap:
  - count=0, stop_level=7 → only 0x10007 then 0x10100.
  - base=0xFFFE, stride=3, count=3 → 0x0FFFE, 0x00001, 0x00004 (wrap).
- clk_en gating: de-assert clk_en for 3 cycles mid-EMIT with ready_in=1.
  - Outputs are frozen and no words are consumed; the sequence resumes exactly after clk_en returns.
- Start and reset:
  - start pulsed while busy → ignored, and the in-flight sequence completes unchanged.
  - rst_n=0 during EMIT → the next cycle shows valid_out=0, busy=0, data_out=0.
  - A subsequent start restarts from base.
